// File: rtl/vend_pkg.sv
// Types and constants shared between vending_machine and change_dispenser:
// dispenser FSM states, hopper request bit positions and coin/key codes.
package vend_pkg;

  typedef enum logic [2:0] {
    DISP_IDLE     = 3'd0,
    DISP_SELECT   = 3'd1,
    DISP_WAIT_ACK = 3'd2,
    DISP_DONE     = 3'd3,
    DISP_FAULT    = 3'd4
  } disp_state_e;

  localparam int HOP_BIG     = 1;
  localparam int HOP_SMALL   = 0;
  localparam int DEF_BIG_VAL = 5;

  typedef enum logic [1:0] {
    COIN_NONE  = 2'd0,
    COIN_SMALL = 2'd1,
    COIN_BIG   = 2'd2
  } coin_e;

  typedef enum logic [2:0] {
    KEY_NONE   = 3'd0,
    KEY_ITEM0  = 3'd1,
    KEY_ITEM1  = 3'd2,
    KEY_ITEM2  = 3'd3,
    KEY_ITEM3  = 3'd4,
    KEY_CANCEL = 3'd5
  } key_e;

  function automatic logic [1:0] hopMask(input logic big);
    logic [1:0] mask;
    mask = '0;
    if (big) mask[HOP_BIG] = 1'b1;
    else     mask[HOP_SMALL] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change request, hopper handshake and status bundle between the vending side
// (master) and the change dispenser (slave).
interface change_dispenser_if #(
  parameter int AMT_W = 4
);

  logic             chg_valid;
  logic [AMT_W-1:0] chg_amount;
  logic             chg_ready;
  logic             big_empty;
  logic             small_empty;
  logic [1:0]       hop_req;
  logic             hop_ack;
  logic             busy;
  logic             done;
  logic             fault;
  logic             fault_clr;
  logic [AMT_W-1:0] shortfall;
  logic [3:0]       big_cnt;
  logic [3:0]       small_cnt;

  modport master (
    output chg_valid, chg_amount, big_empty, small_empty, hop_ack, fault_clr,
    input  chg_ready, hop_req, busy, done, fault, shortfall, big_cnt, small_cnt
  );

  modport slave (
    input  chg_valid, chg_amount, big_empty, small_empty, hop_ack, fault_clr,
    output chg_ready, hop_req, busy, done, fault, shortfall, big_cnt, small_cnt
  );

endinterface

// File: rtl/change_dispenser_ack_watchdog.sv
// Counts cycles spent waiting for a hopper ack; expired_o rises once TIMEOUT
// cycles have elapsed without a clear.
module ack_watchdog #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) cnt_d = '0;
    else if (!expired_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays one change request greedily from a big and a small
// coin hopper, one req/ack handshake per coin, with a watchdog per coin.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W   = 4,
  parameter int BIG_VAL = DEF_BIG_VAL,
  parameter int TIMEOUT = 1000
) (
  input logic clk,
  input logic rst,
  change_dispenser_if.slave bus
);

  localparam logic [AMT_W-1:0] BIG_AMT = AMT_W'(BIG_VAL);
  localparam logic [AMT_W-1:0] ONE_AMT = AMT_W'(1);

  disp_state_e      state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic             bigSel_q, bigSel_d;
  logic [1:0]       hopReq_q, hopReq_d;
  logic [3:0]       bigCnt_q, bigCnt_d;
  logic [3:0]       smallCnt_q, smallCnt_d;
  logic             done_q, done_d;
  logic             ackExpired;
  logic             canBig, canSmall;

  assign canBig   = (remaining_q >= BIG_AMT) && !bus.big_empty;
  assign canSmall = (remaining_q != '0) && !bus.small_empty;

  ack_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (bus.hop_ack),
    .en_i     (state_q == DISP_WAIT_ACK),
    .expired_o(ackExpired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= DISP_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISP_IDLE:     if (bus.chg_valid) state_d = DISP_SELECT;
      DISP_SELECT: begin
        if (remaining_q == '0)      state_d = DISP_DONE;
        else if (canBig || canSmall) state_d = DISP_WAIT_ACK;
        else                         state_d = DISP_FAULT;
      end
      DISP_WAIT_ACK: begin
        if (bus.hop_ack)     state_d = DISP_SELECT;
        else if (ackExpired) state_d = DISP_FAULT;
      end
      DISP_DONE:     state_d = DISP_IDLE;
      DISP_FAULT:    if (bus.fault_clr) state_d = DISP_IDLE;
      default:       state_d = DISP_IDLE;
    endcase
  end

  // The request is re-registered each WAIT_ACK cycle, so ack or timeout drops it at the same edge.
  always_comb begin
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    bigSel_d    = bigSel_q;
    hopReq_d    = '0;
    bigCnt_d    = bigCnt_q;
    smallCnt_d  = smallCnt_q;
    done_d      = (state_q == DISP_DONE);
    case (state_q)
      DISP_IDLE: begin
        if (bus.chg_valid) begin
          remaining_d = bus.chg_amount;
          bigCnt_d    = '0;
          smallCnt_d  = '0;
        end
      end
      DISP_SELECT: begin
        if (remaining_q != '0) begin
          if (canBig)        bigSel_d    = 1'b1;
          else if (canSmall) bigSel_d    = 1'b0;
          else               shortfall_d = remaining_q;
        end
      end
      DISP_WAIT_ACK: begin
        if (bus.hop_ack) begin
          if (bigSel_q) begin
            remaining_d = remaining_q - BIG_AMT;
            if (bigCnt_q != 4'hF) bigCnt_d = bigCnt_q + 4'd1;
          end else begin
            remaining_d = remaining_q - ONE_AMT;
            if (smallCnt_q != 4'hF) smallCnt_d = smallCnt_q + 4'd1;
          end
        end else if (ackExpired) begin
          shortfall_d = remaining_q;
        end else begin
          hopReq_d = hopMask(bigSel_q);
        end
      end
      DISP_FAULT: if (bus.fault_clr) shortfall_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      shortfall_q <= '0;
      bigSel_q    <= 1'b0;
      hopReq_q    <= '0;
      bigCnt_q    <= '0;
      smallCnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      bigSel_q    <= bigSel_d;
      hopReq_q    <= hopReq_d;
      bigCnt_q    <= bigCnt_d;
      smallCnt_q  <= smallCnt_d;
      done_q      <= done_d;
    end
  end

  assign bus.chg_ready = (state_q == DISP_IDLE);
  assign bus.busy      = (state_q != DISP_IDLE) && (state_q != DISP_FAULT);
  assign bus.fault     = (state_q == DISP_FAULT);
  assign bus.hop_req   = hopReq_q;
  assign bus.done      = done_q;
  assign bus.shortfall = shortfall_q;
  assign bus.big_cnt   = bigCnt_q;
  assign bus.small_cnt = smallCnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// transactions compared against a greedy payout model.
module tb_change_dispenser;

  localparam int AMT_W   = 4;
  localparam int BIG_VAL = 5;
  localparam int TIMEOUT = 40;
  localparam int BUDGET  = 16 * 9 + TIMEOUT + 20;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] lastBig;
  logic [3:0] lastSmall;

  change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  change_dispenser #(
    .AMT_W  (AMT_W),
    .BIG_VAL(BIG_VAL),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Greedy payout as arithmetic on the amount; jamIdx names the coin the hopper never acks.
  function automatic void modelTxn(input int amount, input bit bigE, input bit smallE, input int jamIdx,
                                   output logic [31:0] seq, output int nCoins, output int nBig,
                                   output int nSmall, output bit flt, output bit jam, output int shortAmt);
    int rem;
    rem = amount; seq = '0; nCoins = 0; nBig = 0; nSmall = 0; flt = 0; jam = 0; shortAmt = 0;
    while (rem > 0 && !flt) begin
      if (rem >= BIG_VAL && !bigE) begin
        seq = (seq << 2) | 32'd2;
        if (nCoins == jamIdx) begin flt = 1; jam = 1; shortAmt = rem; end
        else begin rem -= BIG_VAL; nBig++; end
        nCoins++;
      end else if (!smallE) begin
        seq = (seq << 2) | 32'd1;
        if (nCoins == jamIdx) begin flt = 1; jam = 1; shortAmt = rem; end
        else begin rem -= 1; nSmall++; end
        nCoins++;
      end else begin
        flt = 1;
        shortAmt = rem;
      end
    end
  endfunction

  task automatic doReset();
    rst = 1'b1;
    bus.chg_valid = 1'b0; bus.hop_ack = 1'b0; bus.fault_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    lastBig = '0;
    lastSmall = '0;
  endtask

  task automatic applyStimulus(input int amount, input bit bigE, input bit smallE, input int ackDelay,
                               input int jamIdx, input bit pokeValid);
    logic [31:0] expSeq, obsSeq;
    int expCoins, expBig, expSmall, expShort, nCoins, k, highCycles, riseStep, lastAckStep, viol, expDone;
    bit expFault, expJam, ended, sawDone, sawFault;
    logic [1:0] prevReq;

    modelTxn(amount, bigE, smallE, jamIdx, expSeq, expCoins, expBig, expSmall, expFault, expJam, expShort);
    bus.big_empty = bigE;
    bus.small_empty = smallE;
    checkOutput("readyBeforeTxn", {31'b0, bus.chg_ready}, 32'd1);
    bus.chg_amount = amount[AMT_W-1:0];
    bus.chg_valid = 1'b1;
    step();
    bus.chg_valid = 1'b0;

    obsSeq = '0; nCoins = 0; prevReq = '0; highCycles = 0; riseStep = 0; lastAckStep = 0;
    viol = 0; ended = 0; sawDone = 0; sawFault = 0; k = 0;
    while (!ended && k < BUDGET) begin
      step();
      k++;
      bus.hop_ack = 1'b0;
      bus.chg_valid = 1'b0;
      if (bus.hop_req != 2'b00 && prevReq == 2'b00) begin
        obsSeq = (obsSeq << 2) | {30'b0, bus.hop_req};
        nCoins++;
        riseStep = k;
        highCycles = 0;
        if (nCoins == 1 ? (k != 2) : (k != lastAckStep + 3)) viol++;
        if (pokeValid) begin
          bus.chg_valid = 1'b1;
          bus.chg_amount = AMT_W'($urandom_range(1, 15));
        end
      end
      if (bus.hop_req != 2'b00) begin
        if (bus.hop_req != 2'b01 && bus.hop_req != 2'b10) viol++;
        if (prevReq != 2'b00 && bus.hop_req != prevReq) viol++;
        highCycles++;
        if (highCycles == ackDelay && (nCoins - 1) != jamIdx) begin
          bus.hop_ack = 1'b1;
          lastAckStep = k;
        end
      end
      prevReq = bus.hop_req;
      if (bus.done) begin
        sawDone = 1; ended = 1;
      end else if (bus.fault) begin
        sawFault = 1; ended = 1;
      end else if (bus.busy !== 1'b1 || bus.chg_ready !== 1'b0) begin
        viol++;
      end
    end
    bus.hop_ack = 1'b0;
    bus.chg_valid = 1'b0;

    checkOutput("txnEnded", {31'b0, ended}, 32'd1);
    checkOutput("hopSeq", obsSeq, expSeq);
    checkOutput("bigCnt", {28'b0, bus.big_cnt}, expBig);
    checkOutput("smallCnt", {28'b0, bus.small_cnt}, expSmall);
    checkOutput("faultFlag", {31'b0, sawFault}, {31'b0, expFault});
    checkOutput("reqTiming", viol, 0);
    lastBig = expBig[3:0];
    lastSmall = expSmall[3:0];

    if (sawDone) begin
      expDone = (nCoins == 0) ? 2 : lastAckStep + 3;
      checkOutput("doneStep", k, expDone);
      checkOutput("readyAtDone", {31'b0, bus.chg_ready}, 32'd1);
      step();
      checkOutput("donePulse", {31'b0, bus.done}, 32'd0);
    end else if (sawFault) begin
      checkOutput("shortfall", {28'b0, bus.shortfall}, expShort);
      checkOutput("faultReq", {30'b0, bus.hop_req}, 32'd0);
      checkOutput("faultReady", {30'b0, bus.chg_ready, bus.busy}, 32'd0);
      if (expJam) checkOutput("jamDelay", k - riseStep, TIMEOUT);
      bus.fault_clr = 1'b1;
      step();
      bus.fault_clr = 1'b0;
      checkOutput("clrFault", {31'b0, bus.fault}, 32'd0);
      checkOutput("clrReady", {31'b0, bus.chg_ready}, 32'd1);
      checkOutput("clrShortfall", {28'b0, bus.shortfall}, 32'd0);
      checkOutput("clrCntHold", {24'b0, bus.big_cnt, bus.small_cnt}, {24'b0, lastBig, lastSmall});
    end else begin
      doReset();
    end
  endtask

  task automatic pokeIdleAck();
    bus.hop_ack = 1'b1;
    step();
    bus.hop_ack = 1'b0;
    step();
    checkOutput("idleAckReady", {31'b0, bus.chg_ready}, 32'd1);
    checkOutput("idleAckCnt", {24'b0, bus.big_cnt, bus.small_cnt}, {24'b0, lastBig, lastSmall});
    checkOutput("idleAckReq", {30'b0, bus.hop_req}, 32'd0);
  endtask

  task automatic resetMidWait();
    int n;
    bus.big_empty = 1'b0;
    bus.small_empty = 1'b0;
    bus.chg_amount = AMT_W'(7);
    bus.chg_valid = 1'b1;
    step();
    bus.chg_valid = 1'b0;
    n = 0;
    while (bus.hop_req == 2'b00 && n < 10) begin
      step();
      n++;
    end
    checkOutput("midReqSeen", {30'b0, bus.hop_req}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    lastBig = '0;
    lastSmall = '0;
    checkOutput("midRstReq", {30'b0, bus.hop_req}, 32'd0);
    checkOutput("midRstReady", {31'b0, bus.chg_ready}, 32'd1);
    checkOutput("midRstCnt", {24'b0, bus.big_cnt, bus.small_cnt}, 32'd0);
    checkOutput("midRstFlags", {30'b0, bus.busy, bus.fault}, 32'd0);
  endtask

  initial begin
    int amount, ackDelay, jamIdx, nCoins, nBig, nSmall, sf;
    bit bigE, smallE, flt, jam;
    logic [31:0] seq;

    checks = 0;
    errors = 0;
    bus.chg_amount = '0;
    bus.big_empty = 1'b0;
    bus.small_empty = 1'b0;
    doReset();
    rst = 1'b1;
    step();
    checkOutput("rstReady", {31'b0, bus.chg_ready}, 32'd1);
    checkOutput("rstOutputs", {11'b0, bus.hop_req, bus.busy, bus.done, bus.fault, bus.shortfall,
                               bus.big_cnt, bus.small_cnt}, 32'd0);
    rst = 1'b0;
    step();

    applyStimulus(7, 1'b0, 1'b0, 3, -1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1, -1, 1'b0);
    applyStimulus(7, 1'b1, 1'b0, 2, -1, 1'b0);
    applyStimulus(3, 1'b0, 1'b1, 1, -1, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1, 0, 1'b0);
    applyStimulus(9, 1'b0, 1'b0, 2, -1, 1'b1);
    pokeIdleAck();
    resetMidWait();
    applyStimulus(15, 1'b0, 1'b0, 1, -1, 1'b0);

    for (int t = 0; t < 25; t++) begin
      amount   = $urandom_range(0, 15);
      bigE     = ($urandom_range(0, 3) == 0);
      smallE   = ($urandom_range(0, 4) == 0);
      ackDelay = $urandom_range(1, 4);
      modelTxn(amount, bigE, smallE, -1, seq, nCoins, nBig, nSmall, flt, jam, sf);
      jamIdx = -1;
      if (nCoins > 0 && $urandom_range(0, 4) == 0) jamIdx = $urandom_range(0, nCoins - 1);
      if ($urandom_range(0, 3) == 0) pokeIdleAck();
      applyStimulus(amount, bigE, smallE, ackDelay, jamIdx, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
